// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a single-outstanding imem request and feeds decode through the IF/ID register.
// Optional FETCH_STATS_EN macro adds fetch_count / stall_cycles counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h5400_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_plus4_out,
  output logic        instr_valid,
  output logic [1:0]  dbg_state_o
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_cycles
`endif
);

  // Handshake: an imem transfer happens on a cycle with imem_req=1 and imem_ready=1;
  // while imem_req=1 and imem_ready=0 imem_addr is held. Decode has no ready, it back-pressures with stall.
  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_SKID    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc4_q, if_pc4_d;
  logic        if_valid_q, if_valid_d;
  logic        if_load_valid;
  logic        req_active;
  logic [31:0] pc_plus4;

  assign pc_plus4   = pc_q + 32'd4;
  assign req_active = (state_q != ST_SKID);

  // Gating with the reset pin drops the request the moment reset is asserted.
  assign imem_req     = reset & req_active;
  assign imem_addr    = (state_q == ST_DISCARD) ? req_addr_q : pc_q;
  assign instr_out    = if_instr_q;
  assign pc_plus4_out = if_pc4_q;
  assign instr_valid  = if_valid_q;
  assign dbg_state_o  = state_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    skid_instr_d  = skid_instr_q;
    skid_pc4_d    = skid_pc4_q;
    if_instr_d    = if_instr_q;
    if_pc4_d      = if_pc4_q;
    if_valid_d    = if_valid_q;
    if_load_valid = 1'b0;

    if (redirect_valid) begin
      pc_d         = redirect_target;
      if_instr_d   = NOP_INSTR;
      if_pc4_d     = 32'd0;
      if_valid_d   = 1'b0;
      skid_instr_d = NOP_INSTR;
      skid_pc4_d   = 32'd0;
      // A request still in flight must complete at its old address before refetching.
      if (req_active && !imem_ready) state_d = ST_DISCARD;
      else                           state_d = ST_FETCH;
      if (state_q == ST_FETCH) req_addr_d = pc_q;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_ready) begin
            pc_d = pc_plus4;
            if (!stall) begin
              if_instr_d    = imem_rdata;
              if_pc4_d      = pc_plus4;
              if_valid_d    = 1'b1;
              if_load_valid = 1'b1;
            end else begin
              skid_instr_d = imem_rdata;
              skid_pc4_d   = pc_plus4;
              state_d      = ST_SKID;
            end
          end else if (!stall) begin
            if_instr_d = NOP_INSTR;
            if_valid_d = 1'b0;
          end
        end
        ST_SKID: begin
          if (!stall) begin
            if_instr_d    = skid_instr_q;
            if_pc4_d      = skid_pc4_q;
            if_valid_d    = 1'b1;
            if_load_valid = 1'b1;
            state_d       = ST_FETCH;
          end
        end
        ST_DISCARD: begin
          if (imem_ready) state_d = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      skid_instr_q <= NOP_INSTR;
      skid_pc4_q   <= 32'd0;
      if_instr_q   <= NOP_INSTR;
      if_pc4_q     <= 32'd0;
      if_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      if_instr_q   <= if_instr_d;
      if_pc4_q     <= if_pc4_d;
      if_valid_q   <= if_valid_d;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_q;
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count_q  <= 32'd0;
      stall_cycles_q <= 32'd0;
    end else begin
      if (if_load_valid) fetch_count_q <= fetch_count_q + 32'd1;
      if (stall && (state_q != ST_DISCARD)) stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign fetch_count  = fetch_count_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run against a program-order model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h5400_0000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_plus4_out;
  logic        instr_valid;
  logic [1:0]  dbg_state;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_cycles;
`endif

  int n_cmp;
  int n_fail;
  logic [31:0] exp_q[$];

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .instr_out      (instr_out),
    .pc_plus4_out   (pc_plus4_out),
    .instr_valid    (instr_valid),
    .dbg_state_o    (dbg_state)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count    (fetch_count),
    .stall_cycles   (stall_cycles)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // Driver tasks
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic rdy, input logic rv, input logic [31:0] tgt);
    stall           = s;
    imem_ready      = rdy;
    redirect_valid  = rv;
    redirect_target = tgt;
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    drive(1'b0, 1'b1, 1'b1, tgt);
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    step();
    step();
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_cmp++; if (imem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", imem_addr, RESET_PC); end
    n_cmp++; if (instr_out !== NOP_INSTR) begin n_fail++; $display("FAIL reset_instr: got %h want %h", instr_out, NOP_INSTR); end
    n_cmp++; if (pc_plus4_out !== 32'd0) begin n_fail++; $display("FAIL reset_pc4: got %h want 0", pc_plus4_out); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
  endtask

  task automatic test_stream();
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL stream_req%0d: got %b want 1", i, imem_req); end
      n_cmp++; if (imem_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_addr%0d: got %h want %h", i, imem_addr, 32'(4 * i)); end
      if (i == 0) begin
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_valid0: got %b want 0", instr_valid); end
      end else begin
        n_cmp++; if (instr_out !== mem_word(32'(4 * (i - 1)))) begin n_fail++; $display("FAIL stream_instr%0d: got %h want %h", i, instr_out, mem_word(32'(4 * (i - 1)))); end
        n_cmp++; if (pc_plus4_out !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_pc4%0d: got %h want %h", i, pc_plus4_out, 32'(4 * i)); end
        n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid%0d: got %b want 1", i, instr_valid); end
      end
      step();
    end
  endtask

  task automatic test_wait_states();
    redirect_to(32'h10);
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, (c == 2), 1'b0, 32'd0);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_fail++; $display("FAIL wait_addr%0d: got req=%b addr=%h want req=1 addr=10", c, imem_req, imem_addr); end
      step();
      if (c < 2) begin
        n_cmp++; if (instr_valid !== 1'b0 || instr_out !== NOP_INSTR) begin n_fail++; $display("FAIL wait_bubble%0d: got v=%b instr=%h want v=0 instr=%h", c, instr_valid, instr_out, NOP_INSTR); end
      end
    end
    n_cmp++; if (instr_out !== mem_word(32'h10)) begin n_fail++; $display("FAIL wait_instr: got %h want %h", instr_out, mem_word(32'h10)); end
    n_cmp++; if (pc_plus4_out !== 32'h14 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL wait_pc4: got pc4=%h v=%b want 14 v=1", pc_plus4_out, instr_valid); end
    n_cmp++; if (imem_addr !== 32'h14) begin n_fail++; $display("FAIL wait_next_addr: got %h want 14", imem_addr); end
  endtask

  task automatic test_skid();
    redirect_to(32'h20);
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b1, 1'b0, 32'd0);
      step();
      n_cmp++; if (instr_valid !== 1'b0 || instr_out !== NOP_INSTR || pc_plus4_out !== 32'd0) begin n_fail++; $display("FAIL skid_hold%0d: got v=%b instr=%h pc4=%h want bubble", c, instr_valid, instr_out, pc_plus4_out); end
      n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL skid_req%0d: got %b want 0", c, imem_req); end
    end
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    step();
    n_cmp++; if (instr_out !== mem_word(32'h20) || instr_valid !== 1'b1) begin n_fail++; $display("FAIL skid_instr: got %h v=%b want %h v=1", instr_out, instr_valid, mem_word(32'h20)); end
    n_cmp++; if (pc_plus4_out !== 32'h24) begin n_fail++; $display("FAIL skid_pc4: got %h want 24", pc_plus4_out); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h24) begin n_fail++; $display("FAIL skid_next: got req=%b addr=%h want req=1 addr=24", imem_req, imem_addr); end
  endtask

  task automatic test_discard();
    redirect_to(32'h40);
    drive(1'b0, 1'b0, 1'b1, 32'h100);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL disc_pre: got req=%b addr=%h want 1/40", imem_req, imem_addr); end
    step();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL disc_hold%0d: got req=%b addr=%h want 1/40", c, imem_req, imem_addr); end
      n_cmp++; if (instr_valid !== 1'b0 || instr_out !== NOP_INSTR) begin n_fail++; $display("FAIL disc_bubble%0d: got v=%b instr=%h want bubble", c, instr_valid, instr_out); end
      step();
    end
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    step();
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL disc_drop: got v=%b instr=%h want v=0", instr_valid, instr_out); end
    n_cmp++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL disc_new_addr: got %h want 100", imem_addr); end
    step();
    n_cmp++; if (instr_out !== mem_word(32'h100) || pc_plus4_out !== 32'h104) begin n_fail++; $display("FAIL disc_first: got %h/%h want %h/104", instr_out, pc_plus4_out, mem_word(32'h100)); end
  endtask

  task automatic test_redirect_stall_skid();
    redirect_to(32'h200);
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    step();
    drive(1'b1, 1'b1, 1'b1, 32'h300);
    step();
    n_cmp++; if (instr_valid !== 1'b0 || instr_out !== NOP_INSTR || pc_plus4_out !== 32'd0) begin n_fail++; $display("FAIL rs_bubble: got v=%b instr=%h pc4=%h want bubble", instr_valid, instr_out, pc_plus4_out); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin n_fail++; $display("FAIL rs_addr: got req=%b addr=%h want 1/300", imem_req, imem_addr); end
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    step();
    n_cmp++; if (instr_out !== mem_word(32'h300) || pc_plus4_out !== 32'h304) begin n_fail++; $display("FAIL rs_first: got %h/%h want %h/304", instr_out, pc_plus4_out, mem_word(32'h300)); end
  endtask

  task automatic test_wrap();
    redirect_to(32'hFFFF_FFFC);
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    step();
    n_cmp++; if (instr_out !== mem_word(32'hFFFF_FFFC) || pc_plus4_out !== 32'd0) begin n_fail++; $display("FAIL wrap_pc4: got %h/%h want %h/0", instr_out, pc_plus4_out, mem_word(32'hFFFF_FFFC)); end
    n_cmp++; if (imem_addr !== 32'd0) begin n_fail++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_async_reset();
    redirect_to(32'h80);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin n_fail++; $display("FAIL ar_pre: got req=%b addr=%h want 1/80", imem_req, imem_addr); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL ar_req: got %b want 0", imem_req); end
    n_cmp++; if (imem_addr !== RESET_PC || instr_valid !== 1'b0 || instr_out !== NOP_INSTR) begin n_fail++; $display("FAIL ar_state: got addr=%h v=%b instr=%h want reset values", imem_addr, instr_valid, instr_out); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin n_fail++; $display("FAIL ar_release: got req=%b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC); end
  endtask

  // Program-order model: exp_q holds the PC decode must see next; a redirect restarts it at the target.
  task automatic test_random();
    logic        s, r, rv, prev_pending;
    logic [31:0] tgt, prev_addr, pc;
    int          consumed;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    step();
    reset = 1'b1;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    prev_pending = 1'b0;
    prev_addr    = 32'd0;
    consumed     = 0;
    for (int n = 0; n < 3000; n++) begin
      s   = ($urandom_range(0, 99) < 30);
      r   = ($urandom_range(0, 99) < 60);
      rv  = ($urandom_range(0, 99) < 5);
      tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(0, 1023)) << 2);
      drive(s, r, rv, tgt);
      if (prev_pending) begin
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin n_fail++; $display("FAIL rnd_addr_stable@%0d: got req=%b addr=%h want 1/%h", n, imem_req, imem_addr, prev_addr); end
      end
      if (!instr_valid) begin
        n_cmp++; if (instr_out !== NOP_INSTR) begin n_fail++; $display("FAIL rnd_bubble@%0d: got %h want %h", n, instr_out, NOP_INSTR); end
      end
      if (instr_valid && !stall && !redirect_valid) begin
        pc = exp_q.pop_front();
        n_cmp++; if (pc_plus4_out - 32'd4 !== pc) begin n_fail++; $display("FAIL rnd_pc@%0d: got pc4=%h want %h", n, pc_plus4_out, pc + 32'd4); end
        n_cmp++; if (instr_out !== mem_word(pc)) begin n_fail++; $display("FAIL rnd_instr@%0d: got %h want %h", n, instr_out, mem_word(pc)); end
        exp_q.push_back(pc + 32'd4);
        consumed++;
      end
      if (rv) begin
        exp_q.delete();
        exp_q.push_back(tgt);
      end
      prev_pending = imem_req && !imem_ready;
      prev_addr    = imem_addr;
      step();
    end
    n_cmp++; if (consumed < 100) begin n_fail++; $display("FAIL rnd_progress: got %0d instructions want >= 100", consumed); end
  endtask

  initial begin
    n_cmp           = 0;
    n_fail          = 0;
    reset           = 1'b0;
    stall           = 1'b0;
    imem_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_wait_states();
    test_skid();
    test_discard();
    test_redirect_stall_skid();
    test_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
